// File: rtl/lcd_cmd_sequencer.sv
// Plays a fixed list of LCD commands to a transmitter with a send/next handshake.
// After each accepted command it holds off for a short or a long (clear/home) settling time.
module lcd_cmd_sequencer #(
  parameter int unsigned                  N_CMDS     = 4,
  parameter int unsigned                  DATA_W     = 8,
  parameter logic [N_CMDS*DATA_W-1:0]     CMD_LIST   = {8'h01, 8'h0C, 8'h06, 8'h28},
  parameter int unsigned                  WAIT_SHORT = 2000,
  parameter int unsigned                  WAIT_LONG  = 82000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              next,
  output logic              send,
  output logic [DATA_W-1:0] SF_D,
  output logic              busy,
  output logic              done
);

  localparam int unsigned W_MAX = (WAIT_LONG > WAIT_SHORT) ? WAIT_LONG : WAIT_SHORT;
  localparam int unsigned CNT_W = $clog2(W_MAX + 1);
  localparam int unsigned IDX_W = (N_CMDS > 1) ? $clog2(N_CMDS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_send;
  logic [DATA_W-1:0] r_sfd;
  logic              r_busy;
  logic              r_done;

  logic [1:0]        w_state_nxt;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_send_nxt;
  logic [DATA_W-1:0] w_sfd_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;

  // Constant-index lookup keeps every part-select of CMD_LIST in range.
  function automatic logic [DATA_W-1:0] cmd_at(input int unsigned i);
    logic [DATA_W-1:0] c;
    c = '0;
    for (int unsigned k = 0; k < N_CMDS; k++) begin
      if (k == i) c = CMD_LIST[k*DATA_W +: DATA_W];
    end
    return c;
  endfunction

  // Clear (01) and home (02/03) need the long settling time.
  function automatic logic [CNT_W-1:0] wait_load(input logic [DATA_W-1:0] c);
    logic [7:0] lo;
    lo = 8'(c);
    if (lo == 8'h01 || lo == 8'h02 || lo == 8'h03) return CNT_W'(WAIT_LONG - 1);
    return CNT_W'(WAIT_SHORT - 1);
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_send_nxt  = r_send;
    w_sfd_nxt   = r_sfd;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_ISSUE;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_send_nxt  = 1'b1;
          w_sfd_nxt   = cmd_at(0);
        end
      end
      S_ISSUE: begin
        if (next) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = wait_load(r_sfd);
          w_send_nxt  = 1'b0;
          w_sfd_nxt   = '0;
        end
      end
      S_WAIT: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else if (32'(r_idx) < N_CMDS - 1) begin
          w_state_nxt = S_ISSUE;
          w_idx_nxt   = r_idx + 1'b1;
          w_send_nxt  = 1'b1;
          w_sfd_nxt   = cmd_at(32'(r_idx) + 1);
        end else begin
          w_state_nxt = S_DONE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
        w_cnt_nxt   = '0;
        w_send_nxt  = 1'b0;
        w_sfd_nxt   = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_send  <= 1'b0;
      r_sfd   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_send  <= w_send_nxt;
      r_sfd   <= w_sfd_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign send = r_send;
  assign SF_D = r_sfd;
  assign busy = r_busy;
  assign done = r_done;

endmodule
